// File: rtl/jt51_wr_arbiter_if.sv
// Bus bundle for jt51_wr_arbiter.
// Carries the two requester write channels, the jt51 write strobes and data bus,
// the jt51 status read, and the completion/error/idle status outputs.
//   slave  : the arbiter side (takes requests and busy status, drives the jt51 bus)
//   master : the environment side (requesters, jt51 model, status consumer)
interface jt51_wr_arbiter_if;
    // Requester 0 (init sequencer)
    logic       p0_valid;
    logic [7:0] p0_addr;
    logic [7:0] p0_data;
    logic       p0_ready;
    // Requester 1 (live trackball control)
    logic       p1_valid;
    logic [7:0] p1_addr;
    logic [7:0] p1_data;
    logic       p1_ready;
    // jt51 bus
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d_in;
    logic [7:0] d_out;
    // Status
    logic       done;
    logic       done_port;
    logic       busy_err;
    logic       err_clr;
    logic       idle;

    modport slave (
        input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data, d_out, err_clr,
        output p0_ready, p1_ready, cs_n, wr_n, a0, d_in, done, done_port, busy_err, idle
    );

    modport master (
        output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data, d_out, err_clr,
        input  p0_ready, p1_ready, cs_n, wr_n, a0, d_in, done, done_port, busy_err, idle
    );
endinterface

// File: rtl/jt51_wr_arbiter.sv
// Two-port round-robin write arbiter in front of a jt51 register interface.
// Each accepted request becomes an address write (a0=0) then a data write (a0=1),
// each preceded by a wait on the jt51 busy flag (d_out[7]) bounded by BUSY_TIMEOUT.
// Ports:
//   clk  - rising-edge system clock, shared with jt51
//   rst  - asynchronous active-high reset
//   bus  - jt51_wr_arbiter_if.slave: p0/p1 valid/addr/data/ready, cs_n/wr_n/a0/d_in,
//          d_out, done/done_port, busy_err/err_clr, idle
module jt51_wr_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 1023
) (
    input logic              clk,
    input logic              rst,
    jt51_wr_arbiter_if.slave bus
);

    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StWaitA,
        StSetupA,
        StStrobeA,
        StHoldA,
        StWaitD,
        StSetupD,
        StStrobeD,
        StHoldD
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        strobe_n_q, strobe_n_d;
    logic        a0_q, a0_d;
    logic [7:0]  d_in_q, d_in_d;
    logic        done_q, done_d;
    logic        done_port_q, done_port_d;
    logic        err_q, err_d;
    logic        busy, in_idle, grant1, hs, err_set;
    logic        unused_d_out;

    assign unused_d_out = ^bus.d_out[6:0];
    assign busy         = bus.d_out[7];
    assign in_idle      = (state_q == StIdle);
    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign grant1       = bus.p1_valid & (~bus.p0_valid | ~last_q);
    assign hs           = in_idle & (bus.p0_valid | bus.p1_valid);

    assign bus.p0_ready  = in_idle & bus.p0_valid & ~grant1;
    assign bus.p1_ready  = in_idle & grant1;
    assign bus.cs_n      = strobe_n_q;
    assign bus.wr_n      = strobe_n_q;
    assign bus.a0        = a0_q;
    assign bus.d_in      = d_in_q;
    assign bus.done      = done_q;
    assign bus.done_port = done_port_q;
    assign bus.busy_err  = err_q;
    assign bus.idle      = in_idle;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;  // holding zero outside WAIT states clears it on every entry
        last_d      = last_q;
        port_d      = port_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        done_port_d = done_port_q;
        err_set     = 1'b0;

        case (state_q)
            StIdle: begin
                if (hs) begin
                    state_d = StWaitA;
                    port_d  = grant1;
                    addr_d  = grant1 ? bus.p1_addr : bus.p0_addr;
                    data_d  = grant1 ? bus.p1_data : bus.p0_data;
                end
            end
            StWaitA, StWaitD: begin
                if (busy && (cnt_q != TMO_LAST)) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    // Timeout: carry on as if jt51 were ready, but flag it.
                    state_d = (state_q == StWaitA) ? StSetupA : StSetupD;
                    err_set = busy;
                end
            end
            StSetupA:  state_d = StStrobeA;
            StStrobeA: state_d = StHoldA;
            StHoldA:   state_d = StWaitD;
            StSetupD:  state_d = StStrobeD;
            StStrobeD: state_d = StHoldD;
            StHoldD: begin
                state_d     = StIdle;
                done_d      = 1'b1;
                done_port_d = port_q;
                last_d      = port_q;
            end
            default:   state_d = StIdle;
        endcase

        // Bus outputs are registered from the next state so they line up with it.
        strobe_n_d = ~((state_d == StStrobeA) || (state_d == StStrobeD));
        a0_d       = a0_q;
        d_in_d     = d_in_q;
        if (state_d == StSetupA) begin
            a0_d   = 1'b0;
            d_in_d = addr_q;
        end else if (state_d == StSetupD) begin
            a0_d   = 1'b1;
            d_in_d = data_q;
        end

        err_d = err_set | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strobe_n_q  <= 1'b1;
            a0_q        <= 1'b0;
            d_in_q      <= '0;
            done_q      <= 1'b0;
            done_port_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strobe_n_q  <= strobe_n_d;
            a0_q        <= a0_d;
            d_in_q      <= d_in_d;
            done_q      <= done_d;
            done_port_q <= done_port_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_jt51_wr_arbiter.sv
// Self-checking bench for jt51_wr_arbiter: a timestamp-based model checks the
// default-timeout instance every cycle; a second instance with BUSY_TIMEOUT=8
// gets directed timeout and error-flag checks.
module tb_jt51_wr_arbiter;

    localparam int          TMO_MAIN = 1023;
    localparam int unsigned TMO_T    = 8;

    logic clk = 1'b0;
    logic rst;

    jt51_wr_arbiter_if bus ();
    jt51_wr_arbiter_if bus_t ();

    jt51_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jt51_wr_arbiter #(.BUSY_TIMEOUT(TMO_T)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hs_log[$];

    logic       tr_cs[64];
    logic       tr_a0[64];
    logic       tr_done[64];
    logic       tr_dp[64];
    logic       tr_err[64];
    logic [7:0] tr_din[64];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int strobes(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (tr_cs[k] === 1'b0) n++;
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && bus.p0_valid && bus.p0_ready) hs_log.push_back(0);
        if (!rst && bus.p1_valid && bus.p1_ready) hs_log.push_back(1);
    end

    // Model: on handshake, a wait phase starts next cycle; it ends in the first cycle
    // that sees busy=0 or is the BUSY_TIMEOUT-th wait cycle. Setup, strobe and hold
    // follow in the next three cycles; the done pulse comes one cycle after data hold.
    logic       m_act, m_last, m_port, m_phase, m_wait;
    logic [7:0] m_addr, m_data, e_din;
    logic       e_a0, e_err, e_done, set_err;
    int         m_ws, m_setup, m_strobe, m_hold, m_done, win;

    initial begin : model
        forever begin
            @(negedge clk);
            if (rst) begin
                m_act = 1'b0; m_last = 1'b1; m_wait = 1'b0;
                e_a0 = 1'b0; e_din = 8'h00; e_err = 1'b0;
                m_setup = -1; m_strobe = -1; m_hold = -1; m_done = -1;
            end
            e_done = 1'b0;
            if (m_act && cyc == m_setup) begin
                e_a0  = m_phase;
                e_din = m_phase ? m_data : m_addr;
            end
            if (m_act && cyc == m_done) begin
                e_done = 1'b1;
                m_act  = 1'b0;
                m_last = m_port;
            end
            win = -1;
            if (!m_act) begin
                if (bus.p0_valid && bus.p1_valid) win = m_last ? 0 : 1;
                else if (bus.p0_valid)             win = 0;
                else if (bus.p1_valid)             win = 1;
            end
            chk("m_cs_n", bus.cs_n, !(m_act && cyc == m_strobe));
            chk("m_wr_n", bus.wr_n, !(m_act && cyc == m_strobe));
            chk("m_a0", bus.a0, e_a0);
            chk("m_d_in", bus.d_in, e_din);
            chk("m_done", bus.done, e_done);
            chk("m_idle", bus.idle, !m_act);
            chk("m_p0_ready", bus.p0_ready, win == 0);
            chk("m_p1_ready", bus.p1_ready, win == 1);
            chk("m_busy_err", bus.busy_err, e_err);
            if (e_done) chk("m_done_port", bus.done_port, m_port);

            if (!rst) begin
                set_err = 1'b0;
                if (!m_act && win >= 0) begin
                    m_act   = 1'b1;
                    m_port  = (win == 1);
                    m_addr  = m_port ? bus.p1_addr : bus.p0_addr;
                    m_data  = m_port ? bus.p1_data : bus.p0_data;
                    m_phase = 1'b0;
                    m_wait  = 1'b1;
                    m_ws    = cyc + 1;
                end else if (m_act && m_wait && cyc >= m_ws) begin
                    if (!bus.d_out[7] || (cyc - m_ws + 1) >= TMO_MAIN) begin
                        m_wait   = 1'b0;
                        m_setup  = cyc + 1;
                        m_strobe = cyc + 2;
                        m_hold   = cyc + 3;
                        if (m_phase) m_done = cyc + 4;
                        set_err  = bus.d_out[7];
                    end
                end else if (m_act && !m_wait && !m_phase && cyc == m_hold) begin
                    m_phase = 1'b1;
                    m_wait  = 1'b1;
                    m_ws    = cyc + 1;
                end
                e_err = set_err ? 1'b1 : (bus.err_clr ? 1'b0 : e_err);
            end
        end
    end

    // Present one request, wait for its handshake (cycle 0), then record ncyc cycles.
    // Busy is driven high for cycles b_from..b_to-1 when b_to > b_from.
    task automatic do_write(input bit use_t, input bit port, input logic [7:0] a,
                            input logic [7:0] d, input int b_from, input int b_to,
                            input int ncyc);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (use_t) begin
            bus_t.p0_valid = 1'b1; bus_t.p0_addr = a; bus_t.p0_data = d;
        end else if (port) begin
            bus.p1_valid = 1'b1; bus.p1_addr = a; bus.p1_data = d;
        end else begin
            bus.p0_valid = 1'b1; bus.p0_addr = a; bus.p0_data = d;
        end
        for (int g = 0; g < 50 && !got; g++) begin
            @(negedge clk);
            got = use_t ? bus_t.p0_ready : (port ? bus.p1_ready : bus.p0_ready);
        end
        chk("handshake", got, 1);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bus_t.p0_valid = 1'b0; bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
            end
            if (b_to > b_from) bus.d_out = (k >= b_from && k < b_to) ? 8'h80 : 8'h00;
            @(negedge clk);
            tr_cs[k]   = use_t ? bus_t.cs_n      : bus.cs_n;
            tr_a0[k]   = use_t ? bus_t.a0        : bus.a0;
            tr_din[k]  = use_t ? bus_t.d_in      : bus.d_in;
            tr_done[k] = use_t ? bus_t.done      : bus.done;
            tr_dp[k]   = use_t ? bus_t.done_port : bus.done_port;
            tr_err[k]  = use_t ? bus_t.busy_err  : bus.busy_err;
        end
    endtask

    task automatic wait_idle(input bit use_t);
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (use_t ? bus_t.idle : bus.idle) break;
        end
        chk("drain_idle", use_t ? bus_t.idle : bus.idle, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit h0, h1, seen;
        int n;
        rst = 1'b1;
        bus.p0_valid = 1'b1; bus.p0_addr = 8'h10; bus.p0_data = 8'hA0;
        bus.p1_valid = 1'b1; bus.p1_addr = 8'h20; bus.p1_data = 8'hB0;
        bus.d_out = 8'h00; bus.err_clr = 1'b0;
        bus_t.p0_valid = 1'b0; bus_t.p0_addr = 8'h00; bus_t.p0_data = 8'h00;
        bus_t.p1_valid = 1'b0; bus_t.p1_addr = 8'h00; bus_t.p1_data = 8'h00;
        bus_t.d_out = 8'h00; bus_t.err_clr = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_wr_n", bus.wr_n, 1);
        chk("rst_a0", bus.a0, 0);
        chk("rst_d_in", bus.d_in, 8'h00);
        chk("rst_done", bus.done, 0);
        chk("rst_done_port", bus.done_port, 0);
        chk("rst_busy_err", bus.busy_err, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_tie_p0_ready", bus.p0_ready, 1);
        chk("rst_tie_p1_ready", bus.p1_ready, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Tie from reset: four handshakes, alternating starting with port 0
        n = 0;
        for (int g = 0; g < 200 && n < 4; g++) begin
            @(negedge clk);
            h0 = bus.p0_valid && bus.p0_ready;
            h1 = bus.p1_valid && bus.p1_ready;
            if (h0 || h1) begin
                n++;
                @(posedge clk); #1;
                if (h0) begin bus.p0_addr++; bus.p0_data++; end
                if (h1) begin bus.p1_addr++; bus.p1_data++; end
                if (n == 4) begin bus.p0_valid = 1'b0; bus.p1_valid = 1'b0; end
            end
        end
        chk("tie_handshakes", n, 4);
        wait_idle(1'b0);
        chk("tie_log_size", hs_log.size() >= 4, 1);
        if (hs_log.size() >= 4) begin
            chk("tie_order0", hs_log[0], 0);
            chk("tie_order1", hs_log[1], 1);
            chk("tie_order2", hs_log[2], 0);
            chk("tie_order3", hs_log[3], 1);
        end

        // Single write, minimum latency
        do_write(1'b0, 1'b0, 8'h28, 8'h4A, 0, 0, 12);
        chk("sw_setup_no_strobe", tr_cs[2], 1);
        chk("sw_strobe_a_cs", tr_cs[3], 0);
        chk("sw_strobe_a_a0", tr_a0[3], 0);
        chk("sw_strobe_a_din", tr_din[3], 8'h28);
        chk("sw_strobe_d_cs", tr_cs[7], 0);
        chk("sw_strobe_d_a0", tr_a0[7], 1);
        chk("sw_strobe_d_din", tr_din[7], 8'h4A);
        chk("sw_done", tr_done[9], 1);
        chk("sw_done_port", tr_dp[9], 0);
        chk("sw_done_once", tr_done[8] | tr_done[10], 0);
        chk("sw_strobe_count", strobes(1, 12), 2);

        // Busy stall of 20 cycles in WAIT_D on port 1
        do_write(1'b0, 1'b1, 8'h30, 8'h55, 5, 25, 32);
        chk("stall_no_strobe", strobes(5, 26), 0);
        chk("stall_strobe_d_cs", tr_cs[27], 0);
        chk("stall_strobe_d_a0", tr_a0[27], 1);
        chk("stall_strobe_d_din", tr_din[27], 8'h55);
        chk("stall_done", tr_done[29], 1);
        chk("stall_done_port", tr_dp[29], 1);
        chk("stall_busy_err", tr_err[29], 0);

        // Mixed traffic with random busy, checked by the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            h0 = bus.p0_valid && bus.p0_ready;
            h1 = bus.p1_valid && bus.p1_ready;
            @(posedge clk); #1;
            if (h0) bus.p0_valid = 1'b0;
            if (h1) bus.p1_valid = 1'b0;
            if (!bus.p0_valid && $urandom_range(0, 3) == 0) begin
                bus.p0_valid = 1'b1; bus.p0_addr = 8'($urandom); bus.p0_data = 8'($urandom);
            end
            if (!bus.p1_valid && $urandom_range(0, 3) == 0) begin
                bus.p1_valid = 1'b1; bus.p1_addr = 8'($urandom); bus.p1_data = 8'($urandom);
            end
            bus.d_out = 8'($urandom);
        end
        @(negedge clk);
        @(posedge clk); #1;
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0; bus.d_out = 8'h00;
        wait_idle(1'b0);

        // Reset during STROBE_A
        do_write(1'b0, 1'b0, 8'h11, 8'h22, 0, 0, 3);
        chk("rstmid_strobe", tr_cs[3], 0);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_cs_n", bus.cs_n, 1);
        chk("rstmid_wr_n", bus.wr_n, 1);
        chk("rstmid_idle", bus.idle, 1);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen |= bus.done;
        end
        chk("rstmid_no_done", seen, 0);
        do_write(1'b0, 1'b1, 8'h44, 8'h66, 0, 0, 12);
        chk("rstmid_next_din", tr_din[7], 8'h66);
        chk("rstmid_next_done", tr_done[9], 1);
        chk("rstmid_next_port", tr_dp[9], 1);

        // Timeout on the BUSY_TIMEOUT=8 instance with busy stuck high
        bus_t.d_out = 8'h80;
        do_write(1'b1, 1'b0, 8'h5A, 8'hC3, 0, 0, 24);
        chk("tmo_no_early_strobe", strobes(1, 9), 0);
        chk("tmo_strobe_a_cs", tr_cs[10], 0);
        chk("tmo_strobe_a_a0", tr_a0[10], 0);
        chk("tmo_strobe_a_din", tr_din[10], 8'h5A);
        chk("tmo_err_before", tr_err[8], 0);
        chk("tmo_err_set", tr_err[9], 1);
        chk("tmo_strobe_d_cs", tr_cs[21], 0);
        chk("tmo_strobe_d_din", tr_din[21], 8'hC3);
        chk("tmo_done", tr_done[23], 1);
        chk("tmo_err_sticky", tr_err[24], 1);
        @(posedge clk); #1 bus_t.err_clr = 1'b1;
        @(posedge clk); #1 bus_t.err_clr = 1'b0;
        @(negedge clk);
        chk("tmo_err_cleared", bus_t.busy_err, 0);

        // Set beats clear when both happen on the same edge
        bus_t.err_clr = 1'b1;
        do_write(1'b1, 1'b0, 8'h01, 8'h02, 0, 0, 12);
        chk("tmo_clr_held_low", tr_err[8], 0);
        chk("tmo_set_beats_clr", tr_err[9], 1);
        chk("tmo_clr_after_set", tr_err[10], 0);
        @(posedge clk); #1;
        bus_t.err_clr = 1'b0;
        bus_t.d_out   = 8'h00;
        wait_idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
